// File: rtl/seg_scan_decoder_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan decoder.
// Holds the FSM state encoding, the segment-pattern table and sample payload.
package seg_scan_decoder_pkg;

    localparam int unsigned NUM_DIGITS = 3;
    localparam int unsigned SEG_W      = 8;
    localparam int unsigned SEG_PAT_W  = 7;
    localparam int unsigned NIB_W      = 4;
    localparam int unsigned BCD_W      = NUM_DIGITS * NIB_W;
    localparam int unsigned CNT_W      = 8;
    localparam int unsigned TMO_W      = 20;

    localparam logic [NIB_W-1:0] NIB_INVALID = 4'hF;

    // Active-high {g,f,e,d,c,b,a} patterns for decimal digits
    localparam logic [SEG_PAT_W-1:0] SEG_DIGIT_0 = 7'h3F;
    localparam logic [SEG_PAT_W-1:0] SEG_DIGIT_1 = 7'h06;
    localparam logic [SEG_PAT_W-1:0] SEG_DIGIT_2 = 7'h5B;
    localparam logic [SEG_PAT_W-1:0] SEG_DIGIT_3 = 7'h4F;
    localparam logic [SEG_PAT_W-1:0] SEG_DIGIT_4 = 7'h66;
    localparam logic [SEG_PAT_W-1:0] SEG_DIGIT_5 = 7'h6D;
    localparam logic [SEG_PAT_W-1:0] SEG_DIGIT_6 = 7'h7D;
    localparam logic [SEG_PAT_W-1:0] SEG_DIGIT_7 = 7'h07;
    localparam logic [SEG_PAT_W-1:0] SEG_DIGIT_8 = 7'h7F;
    localparam logic [SEG_PAT_W-1:0] SEG_DIGIT_9 = 7'h6F;

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    typedef struct packed {
        logic [NUM_DIGITS-1:0] en;
        logic [SEG_W-1:0]      seg;
    } sample_t;

    function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
        return (v != '0) && ((v & (v - NUM_DIGITS'(1))) == '0);
    endfunction

endpackage

// File: rtl/seg_scan_decoder_seg7.sv
// Combinational seven-segment pattern to BCD nibble lookup.
// Unrecognised patterns map to the invalid nibble and raise invalid_c.
module seg7_to_bcd
    import seg_scan_decoder_pkg::*;
(
    input  logic [SEG_PAT_W-1:0] pattern,
    output logic [NIB_W-1:0]     nibble_c,
    output logic                 invalid_c
);

    always_comb begin
        nibble_c = NIB_INVALID;
        case (pattern)
            SEG_DIGIT_0: nibble_c = NIB_W'(0);
            SEG_DIGIT_1: nibble_c = NIB_W'(1);
            SEG_DIGIT_2: nibble_c = NIB_W'(2);
            SEG_DIGIT_3: nibble_c = NIB_W'(3);
            SEG_DIGIT_4: nibble_c = NIB_W'(4);
            SEG_DIGIT_5: nibble_c = NIB_W'(5);
            SEG_DIGIT_6: nibble_c = NIB_W'(6);
            SEG_DIGIT_7: nibble_c = NIB_W'(7);
            SEG_DIGIT_8: nibble_c = NIB_W'(8);
            SEG_DIGIT_9: nibble_c = NIB_W'(9);
            default:     nibble_c = NIB_INVALID;
        endcase
        // No legal digit decodes to F, so the nibble itself flags the error
        invalid_c = (nibble_c == NIB_INVALID);
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers a 3-digit BCD value from a multiplexed seven-segment display bus
// by debouncing each digit slot and publishing a frame once all three are seen.
module seg_scan_decoder
    import seg_scan_decoder_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_DIGITS-1:0] Enable,
    input  logic [SEG_W-1:0]      SevenSegment,
    output logic [BCD_W-1:0]      bcd,
    output logic                  bcd_valid,
    output logic [NUM_DIGITS-1:0] dp,
    output logic                  seg_err,
    output logic                  stale
);

    localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);
    localparam logic [TMO_W-1:0] TMO_MAX    = TMO_W'(TIMEOUT_CYCLES);

    logic [NUM_DIGITS-1:0] en_s1_q, en_s1_d, en_s2_q, en_s2_d;
    logic [SEG_W-1:0]      seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    sample_t               ref_smp_q, ref_smp_d;

    logic [NUM_DIGITS-1:0][NIB_W-1:0] shadow_q, shadow_d;
    logic [NUM_DIGITS-1:0] dp_sh_q, dp_sh_d;
    logic [NUM_DIGITS-1:0] seen_q, seen_d;
    logic                  err_pend_q, err_pend_d;

    logic [BCD_W-1:0]      bcd_q, bcd_d;
    logic [NUM_DIGITS-1:0] dp_q, dp_d;
    logic                  bcd_valid_q, bcd_valid_d;
    logic                  seg_err_q, seg_err_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  stale_q, stale_d;

    sample_t               smp_c;
    logic                  cand_c;
    logic                  same_c;
    logic                  accept_c;
    logic [NIB_W-1:0]      nibble_c;
    logic                  invalid_c;

    seg7_to_bcd u_seg7_to_bcd (
        .pattern   (smp_c.seg[SEG_PAT_W-1:0]),
        .nibble_c  (nibble_c),
        .invalid_c (invalid_c)
    );

    // Two-flop synchronizers on the asynchronous display bus
    always_comb begin
        en_s1_d  = Enable;
        en_s2_d  = en_s1_q;
        seg_s1_d = SevenSegment;
        seg_s2_d = seg_s1_q;
    end

    // Debounce FSM: a digit is accepted once it has been stable long enough
    always_comb begin
        smp_c     = '{en: en_s2_q, seg: seg_s2_q};
        cand_c    = is_onehot(en_s2_q);
        same_c    = (smp_c == ref_smp_q);
        state_d   = state_q;
        cnt_d     = cnt_q;
        ref_smp_d = ref_smp_q;
        accept_c  = 1'b0;

        case (state_q)
            ST_WAIT: begin
                if (cand_c) begin
                    state_d   = ST_SETTLE;
                    cnt_d     = CNT_W'(1);
                    ref_smp_d = smp_c;
                end
            end
            ST_SETTLE: begin
                if (!cand_c) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else if (!same_c) begin
                    cnt_d     = CNT_W'(1);
                    ref_smp_d = smp_c;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == STABLE_MAX) begin
                        accept_c = 1'b1;
                        state_d  = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!same_c) begin
                    if (cand_c) begin
                        state_d   = ST_SETTLE;
                        cnt_d     = CNT_W'(1);
                        ref_smp_d = smp_c;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
        endcase
    end

    // Frame assembly: shadow accepted digits, publish when all slots are seen
    always_comb begin
        shadow_d    = shadow_q;
        dp_sh_d     = dp_sh_q;
        seen_d      = seen_q;
        err_pend_d  = err_pend_q;
        bcd_d       = bcd_q;
        dp_d        = dp_q;
        seg_err_d   = seg_err_q;
        bcd_valid_d = 1'b0;

        if (accept_c) begin
            for (int i = 0; i < int'(NUM_DIGITS); i++) begin
                if (smp_c.en[i]) begin
                    shadow_d[i] = nibble_c;
                    dp_sh_d[i]  = smp_c.seg[SEG_W-1];
                end
            end
            seen_d     = seen_q | smp_c.en;
            err_pend_d = err_pend_q | invalid_c;
            if (seen_d == '1) begin
                bcd_d       = shadow_d;
                dp_d        = dp_sh_d;
                seg_err_d   = err_pend_d;
                bcd_valid_d = 1'b1;
                seen_d      = '0;
                err_pend_d  = 1'b0;
            end
        end
    end

    // Saturating idle timer since the last accepted digit
    always_comb begin
        if (accept_c) begin
            tmo_d = '0;
        end else if (tmo_q == TMO_MAX) begin
            tmo_d = tmo_q;
        end else begin
            tmo_d = tmo_q + TMO_W'(1);
        end
        stale_d = (tmo_d == TMO_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en_s1_q     <= '0;
            en_s2_q     <= '0;
            seg_s1_q    <= '0;
            seg_s2_q    <= '0;
            state_q     <= ST_WAIT;
            cnt_q       <= '0;
            ref_smp_q   <= '0;
            shadow_q    <= '0;
            dp_sh_q     <= '0;
            seen_q      <= '0;
            err_pend_q  <= 1'b0;
            bcd_q       <= '0;
            dp_q        <= '0;
            bcd_valid_q <= 1'b0;
            seg_err_q   <= 1'b0;
            tmo_q       <= '0;
            stale_q     <= 1'b0;
        end else begin
            en_s1_q     <= en_s1_d;
            en_s2_q     <= en_s2_d;
            seg_s1_q    <= seg_s1_d;
            seg_s2_q    <= seg_s2_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ref_smp_q   <= ref_smp_d;
            shadow_q    <= shadow_d;
            dp_sh_q     <= dp_sh_d;
            seen_q      <= seen_d;
            err_pend_q  <= err_pend_d;
            bcd_q       <= bcd_d;
            dp_q        <= dp_d;
            bcd_valid_q <= bcd_valid_d;
            seg_err_q   <= seg_err_d;
            tmo_q       <= tmo_d;
            stale_q     <= stale_d;
        end
    end

    assign bcd       = bcd_q;
    assign bcd_valid = bcd_valid_q;
    assign dp        = dp_q;
    assign seg_err   = seg_err_q;
    assign stale     = stale_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed frames plus random scan
// traffic compared every cycle against a run-length behavioural model.
module tb_seg_scan_decoder;

    localparam int unsigned STABLE = 4;
    localparam int unsigned TMO    = 16;
    localparam logic [6:0] DIGIT_PAT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                              7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  enable = '0;
    logic [7:0]  seven_seg = '0;
    logic [11:0] bcd;
    logic        bcd_valid;
    logic [2:0]  dp;
    logic        seg_err;
    logic        stale;

    int n_checks = 0;
    int n_fail   = 0;
    int valid_pulses = 0;

    always #5 clk = ~clk;

    seg_scan_decoder #(
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .Enable       (enable),
        .SevenSegment (seven_seg),
        .bcd          (bcd),
        .bcd_valid    (bcd_valid),
        .dp           (dp),
        .seg_err      (seg_err),
        .stale        (stale)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int decode_digit(input logic [6:0] pat);
        for (int d = 0; d < 10; d++) begin
            if (DIGIT_PAT[d] == pat) return d;
        end
        return 15;
    endfunction

    // Reference model: inputs seen two clocks late, accepted after a run of STABLE identical one-hot samples
    logic [10:0] pipe1, pipe2, prev_s;
    int          run;
    int          tmo;
    logic [3:0]  m_shadow [3];
    logic [2:0]  m_dps;
    logic [2:0]  m_seen;
    logic        m_err;
    logic [11:0] e_bcd;
    logic [2:0]  e_dp;
    logic        e_valid, e_err, e_stale;

    always @(posedge clk or posedge rst) begin : model
        logic [10:0] s;
        int          idx;
        int          dig;
        if (rst) begin
            pipe1 = '0; pipe2 = '0; prev_s = '0; run = 0; tmo = 0;
            for (int k = 0; k < 3; k++) m_shadow[k] = '0;
            m_dps = '0; m_seen = '0; m_err = 1'b0;
            e_bcd = '0; e_dp = '0; e_valid = 1'b0; e_err = 1'b0; e_stale = 1'b0;
        end else begin
            s = pipe2;
            pipe2 = pipe1;
            pipe1 = {enable, seven_seg};
            e_valid = 1'b0;
            if ($countones(s[10:8]) != 1) run = 0;
            else if (run > 0 && s == prev_s) run = (run < 1000) ? run + 1 : run;
            else run = 1;
            prev_s = s;
            if (run == int'(STABLE)) begin
                idx = 0;
                for (int k = 0; k < 3; k++) if (s[8+k]) idx = k;
                dig = decode_digit(s[6:0]);
                m_shadow[idx] = 4'(dig);
                m_dps[idx] = s[7];
                m_seen[idx] = 1'b1;
                if (dig == 15) m_err = 1'b1;
                if (m_seen == 3'b111) begin
                    e_bcd = {m_shadow[2], m_shadow[1], m_shadow[0]};
                    e_dp = m_dps;
                    e_err = m_err;
                    e_valid = 1'b1;
                    m_seen = '0;
                    m_err = 1'b0;
                end
                tmo = 0;
            end else if (tmo < int'(TMO)) begin
                tmo = tmo + 1;
            end
            e_stale = (tmo == int'(TMO));
        end
    end

    // Cycle-by-cycle comparison away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            check_eq("bcd", 32'(bcd), 32'(e_bcd));
            check_eq("bcd_valid", 32'(bcd_valid), 32'(e_valid));
            check_eq("dp", 32'(dp), 32'(e_dp));
            check_eq("seg_err", 32'(seg_err), 32'(e_err));
            check_eq("stale", 32'(stale), 32'(e_stale));
            if (bcd_valid) valid_pulses++;
        end
    end

    task automatic drive(input logic [2:0] en, input logic [7:0] seg, input int cycles);
        enable = en;
        seven_seg = seg;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic apply_reset();
        enable = '0;
        seven_seg = '0;
        rst = 1'b1;
        #1;
        check_eq("rst_bcd", 32'(bcd), 32'h0);
        check_eq("rst_valid", 32'(bcd_valid), 32'h0);
        check_eq("rst_dp", 32'(dp), 32'h0);
        check_eq("rst_seg_err", 32'(seg_err), 32'h0);
        check_eq("rst_stale", 32'(stale), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int base;
        int sel;
        logic [2:0] en_r;
        logic [7:0] seg_r;

        repeat (2) @(negedge clk);
        apply_reset();

        // Idle timeout, then recovery on a single accepted digit
        drive(3'b000, 8'h00, 20);
        check_eq("stale_idle", 32'(stale), 32'h1);
        drive(3'b001, 8'h3F, 8);
        drive(3'b000, 8'h00, 4);
        check_eq("stale_cleared", 32'(stale), 32'h0);

        // Clean frame 7,4,1
        apply_reset();
        base = valid_pulses;
        drive(3'b001, 8'h07, 8);
        drive(3'b010, 8'h66, 8);
        drive(3'b100, 8'h06, 8);
        drive(3'b000, 8'h00, 4);
        check_eq("frame147_pulses", 32'(valid_pulses - base), 32'd1);
        check_eq("frame147_bcd", 32'(bcd), 32'h147);
        check_eq("frame147_err", 32'(seg_err), 32'h0);

        // Every digit one cycle short of acceptance
        apply_reset();
        base = valid_pulses;
        for (int r = 0; r < 5; r++) begin
            drive(3'b001, 8'h07, int'(STABLE) - 1);
            drive(3'b010, 8'h66, int'(STABLE) - 1);
            drive(3'b100, 8'h06, int'(STABLE) - 1);
        end
        drive(3'b000, 8'h00, 4);
        check_eq("short_pulses", 32'(valid_pulses - base), 32'd0);
        check_eq("short_bcd", 32'(bcd), 32'h0);

        // Bad pattern on digit 1, then a clean frame clears the error
        apply_reset();
        drive(3'b001, 8'h3F, 8);
        drive(3'b010, 8'h49, 8);
        drive(3'b100, 8'h5B, 8);
        drive(3'b000, 8'h00, 4);
        check_eq("bad_bcd", 32'(bcd), 32'h2F0);
        check_eq("bad_err", 32'(seg_err), 32'h1);
        drive(3'b001, 8'h06, 8);
        drive(3'b010, 8'h06, 8);
        drive(3'b100, 8'h06, 8);
        drive(3'b000, 8'h00, 4);
        check_eq("clean_bcd", 32'(bcd), 32'h111);
        check_eq("clean_err", 32'(seg_err), 32'h0);

        // Multi-hot enable must not touch shadows or the seen mask
        apply_reset();
        base = valid_pulses;
        drive(3'b001, 8'h6D, 8);
        drive(3'b011, 8'h7D, 20);
        check_eq("multihot_pulses", 32'(valid_pulses - base), 32'd0);
        drive(3'b010, 8'h4F, 8);
        drive(3'b000, 8'h00, 4);
        check_eq("multihot_nopub", 32'(valid_pulses - base), 32'd0);
        drive(3'b100, 8'h7F, 8);
        drive(3'b000, 8'h00, 4);
        check_eq("multihot_bcd", 32'(bcd), 32'h835);
        check_eq("multihot_pulses2", 32'(valid_pulses - base), 32'd1);

        // Reset mid-frame discards the partial frame
        base = valid_pulses;
        drive(3'b001, 8'h3F, 8);
        drive(3'b010, 8'h3F, 8);
        apply_reset();
        drive(3'b001, 8'h6F, 8);
        drive(3'b010, 8'hEF, 8);
        drive(3'b100, 8'h6F, 8);
        drive(3'b000, 8'h00, 4);
        check_eq("rst_frame_pulses", 32'(valid_pulses - base), 32'd1);
        check_eq("rst_frame_bcd", 32'(bcd), 32'h999);
        check_eq("rst_frame_dp", 32'(dp), 32'h2);

        // Random scan traffic against the model
        for (int i = 0; i < 400; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0) en_r = 3'($urandom_range(0, 7));
            else en_r = 3'(1 << $urandom_range(0, 2));
            sel = int'($urandom_range(0, 9));
            if ($urandom_range(0, 7) == 0) seg_r = 8'($urandom);
            else seg_r = {1'($urandom_range(0, 1)), DIGIT_PAT[sel]};
            drive(en_r, seg_r, int'($urandom_range(1, 9)));
        end
        drive(3'b000, 8'h00, 24);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
SEG_SCAN_DECODER -- requirements
Module: seg_scan_decoder

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive identical synchronized samples required to accept a digit; legal range 2..255.
REQ-002 Parameter TIMEOUT_CYCLES, default 65535: cycles without an accepted digit before stale asserts; legal range 16..2^20-1.
REQ-003 clk  input  1  single clock for all logic; rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 Enable  input  3  multiplexed digit-select from the display driver; one-hot, active-high; bit 0 = least-significant digit.
REQ-006 SevenSegment  input  8  segment lines, active-high; bit 7 = dp, bits 6:0 = g,f,e,d,c,b,a.
REQ-007 bcd  output  12  recovered value {digit2, digit1, digit0}, 4 bits per digit.
REQ-008 bcd_valid  output  1  one-cycle pulse when bcd updates.
REQ-009 dp  output  3  recovered decimal-point bit per digit, updated with bcd.
REQ-010 seg_err  output  1  at least one unrecognised segment pattern in the frame just reported.
REQ-011 stale  output  1  no digit accepted for TIMEOUT_CYCLES cycles.

Function
REQ-012 Enable and SevenSegment each pass through a 2-flop synchronizer; all other logic uses synchronized values only (2-cycle input latency).
REQ-013 A sample is a candidate only if synchronized Enable has exactly one bit set; all-zero or multi-hot samples return the FSM to WAIT.
REQ-014 FSM states: WAIT, SETTLE, HOLD.
REQ-015 WAIT -> SETTLE on a candidate; stability counter loads 1 and the reference sample {Enable, SevenSegment} is captured.
REQ-016 SETTLE: an identical sample increments the counter; when the counter reaches STABLE_CYCLES, the digit is accepted and the FSM moves to HOLD in that same cycle.
REQ-017 SETTLE: a differing candidate restarts SETTLE with the new reference and counter = 1; a non-candidate moves to WAIT.
REQ-018 HOLD: remains while the sample is unchanged; any change moves to SETTLE (candidate) or WAIT (non-candidate); a digit is accepted at most once per HOLD.
REQ-019 Decode table, bits 6:0 -> nibble: 3F=0, 06=1, 5B=2, 4F=3, 66=4, 6D=5, 7D=6, 07=7, 7F=8, 6F=9; any other pattern yields nibble F and sets a pending error flag.
REQ-020 On acceptance: the nibble and dp are written to the shadow slot indexed by the set Enable bit, and that bit is set in a 3-bit seen mask.
REQ-021 If an acceptance makes the seen mask 111: on the next clock, bcd and dp load from the shadows (including the digit just accepted), seg_err loads the pending error flag, and bcd_valid pulses for one cycle; in the same cycle the mask and pending error clear.
REQ-022 Re-accepting an already-seen digit before the frame completes overwrites its shadow slot; the mask is unchanged.
REQ-023 bcd, dp and seg_err hold their values between frames.
REQ-024 Timeout counter: clears on every acceptance, otherwise increments, saturating at TIMEOUT_CYCLES; stale = (counter == TIMEOUT_CYCLES).
REQ-025 Acceptance clears stale on the next cycle; stale does not affect bcd, dp or seg_err.

Reset
REQ-026 On rst: FSM = WAIT, synchronizers, counters, shadows, seen mask and pending error = 0; bcd = 000, dp = 000, bcd_valid = 0, seg_err = 0, stale = 0.
REQ-027 rst asserted mid-frame discards the partial frame; no bcd_valid is produced for it.

Structure
REQ-028 A shared package holds the FSM state enum, the segment-to-nibble table constants and the invalid-nibble constant F.
REQ-029 One sub-module, seg7_to_bcd: purely combinational; 7-bit pattern in, nibble plus invalid flag out.

Verification
REQ-030 Scan digits 0,1,2 showing 7,4,1 (07,66,06) for 8 cycles each -> one bcd_valid pulse, bcd = 0x147, seg_err = 0.
REQ-031 Hold each digit for only STABLE_CYCLES-1 cycles -> no acceptance and no bcd_valid.
REQ-032 Digit 1 shows pattern 0x49 and the rest are valid -> bcd[7:4] = F and seg_err = 1 for that frame; the next clean frame clears seg_err to 0.
REQ-033 Enable = 011 held for 20 cycles -> FSM stays in WAIT; no shadow or mask change.
REQ-034 TIMEOUT_CYCLES = 16 with inputs idle -> stale = 1 from cycle 16 onward; one valid digit makes stale = 0 again.
REQ-035 rst pulsed after two digits are accepted, then a full frame 9,9,9 -> exactly one bcd_valid, bcd = 0x999.
